fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage directly upstream of the control decoder. Owns the PC.
//  Issues requests to instruction memory, which has variable latency.
//  Presents each fetched 16-bit instruction with a valid/ready handshake, along with its
//  opcode field, its PC and PC+2.
//  Applies branch/jump redirects from the execute stage and stops fetching after HALT.
// PARAMETERS
//  DATA_W    16       instruction and address width
//  RESET_PC  16'h0000 PC loaded on reset
// PORTS
//  clk         in   1       single clock; all state changes on its rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  imem_req    out  1       fetch request; held high until imem_ack
//  imem_addr   out  DATA_W  fetch address; stable while imem_req=1
//  imem_ack    in   1       rdata valid this cycle; only meaningful while imem_req=1
//  imem_rdata  in   DATA_W  fetched instruction word
//  out_valid   out  1       out_instr/out_pc/out_pc_plus2 valid
//  out_ready   in   1       decoder accepts; transfer when out_valid & out_ready
//  out_instr   out  DATA_W  instruction word
//  out_opcode  out  5       out_instr[15:11]; feeds decoder opcode input
//  out_pc      out  DATA_W  address of out_instr
//  out_pc_plus2 out DATA_W  out_pc+2 (mod 2^16); used as link value for JAL/JALR
//  redirect    in   1       taken branch/jump this cycle
//  redirect_pc in   DATA_W  target address; valid when redirect=1
//  halted      out  1       HALT has been consumed; fetch stopped
//  align_err   out  1       misaligned target; only when FETCH_ALIGN_CHECK_EN is defined, else tied 0
// BEHAVIOUR
//  Reset (async, rst_n=0) values:
//   state=IDLE, pc=RESET_PC, imem_req=0, out_valid=0, out_instr=0, halted=0, align_err=0.
//  All outputs are driven from registers or decoded from state; there are no combinational
//  paths from input to output.
//  State transitions:
//   IDLE: next state FETCH, unconditionally.
//   FETCH: imem_req=1, imem_addr=pc.
//    - ack & !redirect: latch rdata into out_instr, next state VALID.
//    - ack & redirect: discard rdata, pc<=redirect_pc, stay in FETCH.
//    - !ack & redirect: tgt<=redirect_pc, next state SQUASH.
//      imem_addr holds the old pc until that request is acked.
//   SQUASH: imem_req=1 with the old address.
//    - A further redirect overwrites tgt.
//    - On ack: discard rdata, pc<=tgt (or redirect_pc if redirect is also high that cycle),
//      next state FETCH.
//   VALID: out_valid=1; all out_* outputs are held stable.
//    - Redirect has priority over handshake: drop the instruction, pc<=redirect_pc, next state FETCH.
//    - Accept with out_opcode==5'b00000 (HALT): next state HALTED.
//    - Accept with any other opcode: pc<=pc+2, next state FETCH.
//    - Otherwise (no accept): stay in VALID.
//   HALTED: halted=1, imem_req=0, out_valid=0. Ignores redirect and ack. Exits only via reset.
//  PC arithmetic is unsigned DATA_W bits and wraps: 16'hFFFE+2 = 16'h0000.
//  Latency: at least 1 cycle from ack to out_valid. Throughput: at most 1 instruction per
//   2 cycles (FETCH->VALID->FETCH).
//  Reset asserted mid-request: the in-flight request is abandoned; no ack is expected after reset.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined:
//   - A redirect whose target has bit0=1 sets align_err=1 and moves to HALTED.
//     In FETCH or SQUASH this happens after the pending ack.
//   - No request is ever issued to an odd address.
//  FETCH_ALIGN_CHECK_EN not defined:
//   - align_err is constant 0.
//   - Bit0 of the target is forced to 0.
// STRUCTURE
//  Shared package isa_pkg holds:
//   - opcode localparams, including OP_HALT=5'b00000 (shared with the control decoder);
//   - INSTR_W=16 and OPCODE_MSB/LSB=15/11;
//   - the fetch state encoding IDLE/FETCH/SQUASH/VALID/HALTED.
//  Sub-module fetch_pc_reg: PC and target registers plus the +2 incrementer.
//  The FSM and the output register stay in fetch_stage.
// TESTING
//  1. Reset, then 2 cycles of ack with rdata 16'h4123:
//     imem_addr=0000; out_valid with out_pc=0000, out_pc_plus2=0002;
//     after accept, next imem_addr=0002.
//  2. out_ready=0 for 5 cycles while VALID: out_instr and out_pc stay constant and imem_req=0.
//  3. Redirect to 0x0040 while FETCH waits for ack (3-cycle latency):
//     addr held at old pc until ack; that data is never presented; next request addr=0040.
//  4. Redirect to 0x0080 in VALID in the same cycle as out_ready=1:
//     instruction dropped; next imem_addr=0080.
//  5. Fetch 16'h0000 (HALT) and accept:
//     halted=1 next cycle; imem_req stays 0 for 10 cycles despite redirect pulses.
//  6. pc=FFFE, accept: next imem_addr=0000.
//     Also with FETCH_ALIGN_CHECK_EN defined: redirect to 0x0013 gives align_err=1 and halted=1.

Source files
------------

// File: rtl/isa_pkg.sv
// ISA constants shared by the fetch stage and the control decoder, plus the
// fetch FSM state encoding.
package isa_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 11;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_LW   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SW   = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_BNE  = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_JAL  = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_JALR = 5'b01011;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SQUASH = 3'd2,
    VALID  = 3'd3,
    HALTED = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// PC and pending-redirect target registers with the wrapping +2 incrementer.
module fetch_pc_reg
  import isa_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_load_i,
  input  logic [DATA_W-1:0] pc_val_i,
  input  logic              pc_inc_i,
  input  logic              tgt_load_i,
  input  logic [DATA_W-1:0] tgt_val_i,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] pc_plus2_o,
  output logic [DATA_W-1:0] tgt_o
);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic [DATA_W-1:0] pc_plus2;

  // Unsigned DATA_W-bit add: FFFE + 2 wraps to 0000
  assign pc_plus2 = pc_q + DATA_W'(2);

  always_comb begin
    pc_d = pc_q;
    if (pc_load_i)     pc_d = pc_val_i;
    else if (pc_inc_i) pc_d = pc_plus2;
  end

  always_comb begin
    tgt_d = tgt_q;
    if (tgt_load_i) tgt_d = tgt_val_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      tgt_q <= RESET_PC;
    end else begin
      pc_q  <= pc_d;
      tgt_q <= tgt_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus2_o = pc_plus2;
  assign tgt_o      = tgt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, talks to variable-latency imem, hands
// instructions to the decoder. Build option: FETCH_ALIGN_CHECK_EN.
module fetch_stage
  import isa_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [DATA_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [DATA_W-1:0]   imem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_instr,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [DATA_W-1:0]   out_pc,
  output logic [DATA_W-1:0]   out_pc_plus2,
  input  logic                redirect,
  input  logic [DATA_W-1:0]   redirect_pc,
  output logic                halted,
  output logic                align_err
);

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  // Without the check an odd target is silently rounded down; with it the raw
  // target is kept so the error can be raised once any pending ack retires.
  function automatic logic [DATA_W-1:0] fix_tgt(input logic [DATA_W-1:0] t);
    return t & ~{{(DATA_W-1){1'b0}}, !ALIGN_CHK};
  endfunction

  function automatic logic odd_tgt(input logic [DATA_W-1:0] t);
    return ALIGN_CHK && t[0];
  endfunction

  fetch_state_e      state_q, state_d;
  logic              imem_req_q, out_valid_q, halted_q, align_err_q;
  logic [DATA_W-1:0] out_instr_q;

  logic              pc_load, pc_inc, tgt_load, instr_load, err_set;
  logic [DATA_W-1:0] pc_val, tgt_val, eff_tgt;
  logic [DATA_W-1:0] pc, pc_plus2, tgt;

  fetch_pc_reg #(
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_load_i  (pc_load),
    .pc_val_i   (pc_val),
    .pc_inc_i   (pc_inc),
    .tgt_load_i (tgt_load),
    .tgt_val_i  (tgt_val),
    .pc_o       (pc),
    .pc_plus2_o (pc_plus2),
    .tgt_o      (tgt)
  );

  // A redirect arriving together with the squash ack is newer than tgt
  assign eff_tgt = redirect ? fix_tgt(redirect_pc) : tgt;

  always_comb begin
    state_d    = state_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_val     = fix_tgt(redirect_pc);
    tgt_load   = 1'b0;
    tgt_val    = fix_tgt(redirect_pc);
    instr_load = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            if (odd_tgt(redirect_pc)) begin
              err_set = 1'b1;
              state_d = HALTED;
            end else begin
              pc_load = 1'b1;
            end
          end else begin
            instr_load = 1'b1;
            state_d    = VALID;
          end
        end else if (redirect) begin
          tgt_load = 1'b1;
          state_d  = SQUASH;
        end
      end
      SQUASH: begin
        if (imem_ack) begin
          if (odd_tgt(eff_tgt)) begin
            err_set = 1'b1;
            state_d = HALTED;
          end else begin
            pc_load = 1'b1;
            pc_val  = eff_tgt;
            state_d = FETCH;
          end
        end else if (redirect) begin
          tgt_load = 1'b1;
        end
      end
      VALID: begin
        if (redirect) begin
          if (odd_tgt(redirect_pc)) begin
            err_set = 1'b1;
            state_d = HALTED;
          end else begin
            pc_load = 1'b1;
            state_d = FETCH;
          end
        end else if (out_ready) begin
          if (out_instr_q[OPCODE_MSB:OPCODE_LSB] == OP_HALT) begin
            state_d = HALTED;
          end else begin
            pc_inc  = 1'b1;
            state_d = FETCH;
          end
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      imem_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      align_err_q <= 1'b0;
      out_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= (state_d == FETCH) || (state_d == SQUASH);
      out_valid_q <= (state_d == VALID);
      halted_q    <= (state_d == HALTED);
      align_err_q <= align_err_q | err_set;
      if (instr_load) out_instr_q <= imem_rdata;
    end
  end

  // pc only moves when leaving SQUASH, so the old address is held until ack
  assign imem_req     = imem_req_q;
  assign imem_addr    = pc;
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_opcode   = out_instr_q[OPCODE_MSB:OPCODE_LSB];
  assign out_pc       = pc;
  assign out_pc_plus2 = pc_plus2;
  assign halted       = halted_q;
  assign align_err    = align_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; fetched words are queued on ack and checked
// when the decoder side accepts them.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [4:0]  out_opcode;
  logic [15:0] out_pc;
  logic [15:0] out_pc_plus2;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;
  logic        align_err;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_opcode   (out_opcode),
    .out_pc       (out_pc),
    .out_pc_plus2 (out_pc_plus2),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halted       (halted),
    .align_err    (align_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $fatal(1, "FAIL timeout: bench did not complete");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a request, then ack after lat cycles with data
  task automatic fetch(input logic [15:0] addr, input logic [15:0] data, input int lat);
    int n = 0;
    while (imem_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    chk("req_addr", {16'd0, imem_addr}, {16'd0, addr});
    for (int i = 1; i < lat; i++) begin
      tick();
      chk("addr_hold", {16'd0, imem_addr}, {16'd0, addr});
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    sb.push_back('{instr: data, pc: addr});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 16'h0;
  endtask

  task automatic accept();
    exp_t e;
    chk("acc_valid", {31'd0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty observed=%h expected=queued entry", out_instr);
    end else begin
      e = sb.pop_front();
      chk("instr",  {16'd0, out_instr}, {16'd0, e.instr});
      chk("pc",     {16'd0, out_pc}, {16'd0, e.pc});
      chk("pc_p2",  {16'd0, out_pc_plus2}, {16'd0, e.pc + 16'd2});
      chk("opcode", {27'd0, out_opcode}, {27'd0, e.instr[15:11]});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic drop();
    exp_t e;
    if (sb.size() != 0) e = sb.pop_front();
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 16'h0;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    #1;
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", {16'd0, out_instr}, 32'd0);
    chk("rst_halt",  {31'd0, halted}, 32'd0);
    chk("rst_aerr",  {31'd0, align_err}, 32'd0);
    chk("rst_pc",    {16'd0, imem_addr}, 32'd0);
    tick();
    rst_n = 1'b1;

    // 1: basic fetch, latency 2
    fetch(16'h0000, 16'h4123, 2);
    accept();
    chk("t1_next", {16'd0, imem_addr}, 32'h0002);

    // 2: backpressure holds outputs and issues no request
    fetch(16'h0002, 16'h5A5A, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", {31'd0, out_valid}, 32'd1);
      chk("t2_instr", {16'd0, out_instr}, 32'h5A5A);
      chk("t2_pc",    {16'd0, out_pc}, 32'h0002);
      chk("t2_req",   {31'd0, imem_req}, 32'd0);
      tick();
    end
    accept();

    // 3: redirect while waiting on a 3-cycle ack
    chk("t3_addr0", {16'd0, imem_addr}, 32'h0004);
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("t3_req",   {31'd0, imem_req}, 32'd1);
    chk("t3_hold1", {16'd0, imem_addr}, 32'h0004);
    tick();
    chk("t3_hold2", {16'd0, imem_addr}, 32'h0004);
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    tick();
    imem_ack = 1'b0;
    chk("t3_novalid", {31'd0, out_valid}, 32'd0);
    chk("t3_new",     {16'd0, imem_addr}, 32'h0040);
    fetch(16'h0040, 16'h2A55, 1);
    accept();

    // 4: redirect beats accept in VALID
    fetch(16'h0042, 16'h3333, 1);
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
    tick();
    out_ready = 1'b0; redirect = 1'b0;
    drop();
    chk("t4_novalid", {31'd0, out_valid}, 32'd0);
    chk("t4_req",     {31'd0, imem_req}, 32'd1);
    chk("t4_addr",    {16'd0, imem_addr}, 32'h0080);

    // 6: PC wrap at FFFE
    fetch(16'h0080, 16'h1111, 1);
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    drop();
    fetch(16'hFFFE, 16'h0801, 3);
    accept();
    chk("t6_wrap", {16'd0, imem_addr}, 32'h0000);

    // ack and redirect together in FETCH: data discarded, stay fetching
    imem_ack = 1'b1; imem_rdata = 16'h7777; redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    imem_ack = 1'b0; redirect = 1'b0;
    chk("fr_novalid", {31'd0, out_valid}, 32'd0);
    chk("fr_addr",    {16'd0, imem_addr}, 32'h0100);

    // 5: HALT is terminal
    fetch(16'h0100, 16'h0000, 2);
    accept();
    chk("t5_halt",  {31'd0, halted}, 32'd1);
    chk("t5_req",   {31'd0, imem_req}, 32'd0);
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      redirect = i[0]; redirect_pc = 16'h0200; imem_ack = 1'b1;
      tick();
      chk("t5_req_hold", {31'd0, imem_req}, 32'd0);
      chk("t5_halt_hold", {31'd0, halted}, 32'd1);
    end
    redirect = 1'b0; imem_ack = 1'b0;

    // reset out of HALTED, then reset again mid-request
    rst_n = 1'b0;
    #2;
    chk("r2_halt", {31'd0, halted}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("r2_req",  {31'd0, imem_req}, 32'd1);
    chk("r2_addr", {16'd0, imem_addr}, 32'h0000);
    rst_n = 1'b0;
    #2;
    chk("r3_req", {31'd0, imem_req}, 32'd0);
    tick();
    rst_n = 1'b1;

    // odd redirect target
    fetch(16'h0000, 16'h4444, 1);
    redirect = 1'b1; redirect_pc = 16'h0013;
    tick();
    redirect = 1'b0;
    drop();
`ifdef FETCH_ALIGN_CHECK_EN
    chk("al_err",  {31'd0, align_err}, 32'd1);
    chk("al_halt", {31'd0, halted}, 32'd1);
    chk("al_req",  {31'd0, imem_req}, 32'd0);
`else
    chk("al_err",  {31'd0, align_err}, 32'd0);
    chk("al_req",  {31'd0, imem_req}, 32'd1);
    chk("al_addr", {16'd0, imem_addr}, 32'h0012);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
